// File: rtl/msf_frame_decoder_if.sv
// Output bundle from the MSF frame decoder to the HH:MM:SS digit chain.
`timescale 1ns/1ps
interface msf_frame_decoder_if;
   logic       inc;
   logic       load;
   logic [1:0] load_hour_msd;
   logic [3:0] load_hour_lsd;
   logic [2:0] load_min_msd;
   logic [3:0] load_min_lsd;
   logic [2:0] load_sec_msd;
   logic [3:0] load_sec_lsd;
   logic       locked;

   modport master (
      output inc, load, load_hour_msd, load_hour_lsd, load_min_msd, load_min_lsd,
             load_sec_msd, load_sec_lsd, locked
   );

   modport slave (
      input inc, load, load_hour_msd, load_hour_lsd, load_min_msd, load_min_lsd,
            load_sec_msd, load_sec_lsd, locked
   );
endinterface

// File: rtl/msf_frame_decoder.sv
// MSF carrier decoder: per-second A/B bit classification, seconds pulses and minute time loads.
// Define MSF_GLITCH_FILTER_EN to put a 3-sample majority filter in front of the edge detector.
`timescale 1ns/1ps
module msf_frame_decoder #(
   parameter int unsigned Unit    = 10,
   parameter int unsigned Tol     = 3,
   parameter int unsigned Holdoff = 90,
   parameter int unsigned Timeout = 150
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                tick_i,
   input  logic                carrier_i,
   msf_frame_decoder_if.master bus
);

   localparam int unsigned LenW   = $clog2(5 * Unit + Tol + 2);
   localparam int unsigned SinceW = $clog2(Timeout + 1);
   // The marker's own edge has already advanced the index past second 59.
   localparam logic [5:0] MarkerIdx = 6'd60;

   typedef enum logic [2:0] {StIdle, StLow1, StGap, StLow2, StHold} state_e;

   state_e            state_q;
   logic              prev_q;
   logic [LenW-1:0]   len_q, len_n;
   logic [SinceW-1:0] since_q, since_n;
   logic [5:0]        sec_idx_q;
   logic              frame_err_q;
   logic [12:0]       a_sr_q;
   logic              b57_q;
   logic              inc_q, load_q, locked_q;
   logic [1:0]        hour_msd_q;
   logic [3:0]        hour_lsd_q;
   logic [2:0]        min_msd_q;
   logic [3:0]        min_lsd_q;
   logic              samp, edge_det, frame_ok;
   logic              to_gap, to_low2, to_hold, cls, cls_a, cls_b, err, marker;

`ifdef MSF_GLITCH_FILTER_EN
   logic [2:0] hist_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hist_q <= '0;
      end else if (tick_i) begin
         hist_q <= {hist_q[1:0], carrier_i};
      end
   end

   assign samp = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
   assign samp = carrier_i;
`endif

   function automatic logic in_win(input int unsigned n, input int unsigned centre);
      return (n + Tol >= centre) && (n <= centre + Tol);
   endfunction

   assign edge_det = prev_q & ~samp;
   assign len_n    = len_q + LenW'(1);
   assign since_n  = (32'(since_q) >= Timeout) ? since_q : since_q + SinceW'(1);

   assign frame_ok = !frame_err_q && (sec_idx_q == MarkerIdx) && (^{a_sr_q, b57_q})
                     && (a_sr_q[10:7] <= 4'd9) && (a_sr_q[3:0] <= 4'd9) && (a_sr_q[6:4] <= 3'd5)
                     && ((a_sr_q[12:11] < 2'd2) || (a_sr_q[12:11] == 2'd2 && a_sr_q[10:7] <= 4'd3));

   always_comb begin
      to_gap  = 1'b0;
      to_low2 = 1'b0;
      to_hold = 1'b0;
      cls     = 1'b0;
      cls_a   = 1'b0;
      cls_b   = 1'b0;
      err     = 1'b0;
      marker  = 1'b0;
      case (state_q)
         StLow1: begin
            if (samp) begin
               to_hold = 1'b1;
               if (in_win(32'(len_n), Unit)) begin
                  to_gap  = 1'b1;
                  to_hold = 1'b0;
               end else if (in_win(32'(len_n), 2 * Unit)) begin
                  cls   = 1'b1;
                  cls_a = 1'b1;
               end else if (in_win(32'(len_n), 3 * Unit)) begin
                  cls   = 1'b1;
                  cls_a = 1'b1;
                  cls_b = 1'b1;
               end else if (in_win(32'(len_n), 5 * Unit)) begin
                  marker = 1'b1;
               end else begin
                  err = 1'b1;
               end
            end else if (32'(len_n) > 5 * Unit + Tol) begin
               err     = 1'b1;
               to_hold = 1'b1;
            end
         end
         StGap: begin
            if (!samp) begin
               if (in_win(32'(len_n), Unit)) begin
                  to_low2 = 1'b1;
               end else begin
                  err     = 1'b1;
                  to_hold = 1'b1;
               end
            end else if (32'(len_n) > Unit + Tol) begin
               cls     = 1'b1;
               to_hold = 1'b1;
            end
         end
         StLow2: begin
            if (samp || 32'(len_n) > Unit + Tol) begin
               to_hold = 1'b1;
               if (samp && in_win(32'(len_n), Unit)) begin
                  cls   = 1'b1;
                  cls_b = 1'b1;
               end else begin
                  err = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         prev_q      <= 1'b0;
         len_q       <= '0;
         since_q     <= '0;
         sec_idx_q   <= '0;
         frame_err_q <= 1'b1;
         a_sr_q      <= '0;
         b57_q       <= 1'b0;
         inc_q       <= 1'b0;
         load_q      <= 1'b0;
         locked_q    <= 1'b0;
         hour_msd_q  <= '0;
         hour_lsd_q  <= '0;
         min_msd_q   <= '0;
         min_lsd_q   <= '0;
      end else begin
         inc_q  <= 1'b0;
         load_q <= 1'b0;
         if (tick_i) begin
            prev_q  <= samp;
            since_q <= since_n;
            len_q   <= len_n;
            case (state_q)
               StIdle: begin
                  if (edge_det) begin
                     inc_q     <= 1'b1;
                     sec_idx_q <= (sec_idx_q == 6'd63) ? sec_idx_q : sec_idx_q + 6'd1;
                     len_q     <= '0;
                     since_q   <= '0;
                     state_q   <= StLow1;
                  end
               end
               StLow1: begin
                  if (to_gap) begin
                     len_q   <= '0;
                     state_q <= StGap;
                  end
               end
               StGap: begin
                  if (to_low2) begin
                     len_q   <= '0;
                     state_q <= StLow2;
                  end
               end
               StHold: begin
                  if (32'(since_n) >= Holdoff) state_q <= StIdle;
               end
               default: ;
            endcase
            if (to_hold) state_q <= StHold;
            if (err) frame_err_q <= 1'b1;
            if (cls) begin
               if (sec_idx_q >= 6'd39 && sec_idx_q <= 6'd51) a_sr_q <= {a_sr_q[11:0], cls_a};
               if (sec_idx_q == 6'd57) b57_q <= cls_b;
            end
            if (marker) begin
               if (frame_ok) begin
                  load_q     <= 1'b1;
                  locked_q   <= 1'b1;
                  hour_msd_q <= a_sr_q[12:11];
                  hour_lsd_q <= a_sr_q[10:7];
                  min_msd_q  <= a_sr_q[6:4];
                  min_lsd_q  <= a_sr_q[3:0];
               end
               sec_idx_q   <= '0;
               frame_err_q <= 1'b0;
            end
            // An edge accepted on this tick restarts the window instead of timing out.
            if (!(state_q == StIdle && edge_det) && 32'(since_n) >= Timeout) begin
               locked_q    <= 1'b0;
               frame_err_q <= 1'b1;
               state_q     <= StIdle;
            end
         end
      end
   end

   assign bus.inc           = inc_q;
   assign bus.load          = load_q;
   assign bus.load_hour_msd = hour_msd_q;
   assign bus.load_hour_lsd = hour_lsd_q;
   assign bus.load_min_msd  = min_msd_q;
   assign bus.load_min_lsd  = min_lsd_q;
   assign bus.load_sec_msd  = '0;
   assign bus.load_sec_lsd  = '0;
   assign bus.locked        = locked_q;

endmodule

// File: tb/tb_msf_frame_decoder.sv
// Directed bench for msf_frame_decoder: table of whole minute frames plus reset/timeout sequences.
`timescale 1ns/1ps
module tb_msf_frame_decoder;
   logic clk = 1'b0;
   logic rst_n, tick, carrier;
   int   n_checks = 0;
   int   n_errors = 0;
   int   inc_cnt  = 0;
   int   load_cnt = 0;
   int   tick_gap = 0;

   always #5 clk = ~clk;

   msf_frame_decoder_if bus ();

   msf_frame_decoder dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .tick_i    (tick),
      .carrier_i (carrier),
      .bus       (bus)
   );

   always @(negedge clk) begin
      if (bus.inc) inc_cnt <= inc_cnt + 1;
      if (bus.load) load_cnt <= load_cnt + 1;
   end

   typedef struct {
      logic [12:0] f;
      bit          flip;
      int          nsec;
      int          exp_loads;
      int          exp_locked;
      logic [12:0] exp_time;
      int          exp_incs;
   } frame_vec_t;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic tk(input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         carrier = lvl;
         tick    = 1'b1;
         @(posedge clk);
         #1;
         if (tick_gap > 0) begin
            tick = 1'b0;
            repeat (tick_gap) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic send_second(input logic a, input logic b);
      if (!a && b) begin
         tk(1'b0, 10);
         tk(1'b1, 10);
         tk(1'b0, 10);
         tk(1'b1, 70);
      end else if (a && b) begin
         tk(1'b0, 30);
         tk(1'b1, 70);
      end else if (a) begin
         tk(1'b0, 20);
         tk(1'b1, 80);
      end else begin
         tk(1'b0, 10);
         tk(1'b1, 90);
      end
   endtask

   task automatic send_marker();
      tk(1'b0, 50);
      tk(1'b1, 50);
   endtask

   task automatic send_secs(input logic [12:0] f, input bit flip, input int first, input int last);
      for (int s = first; s <= last; s++) begin
         logic a, b;
         a = (s >= 39 && s <= 51) ? f[51 - s] : 1'b0;
         b = (s == 57) ? ((~^f) ^ flip) : 1'b0;
         send_second(a, b);
      end
   endtask

   function automatic int time_bus();
      return int'({bus.load_hour_msd, bus.load_hour_lsd, bus.load_min_msd, bus.load_min_lsd,
                   bus.load_sec_msd, bus.load_sec_lsd});
   endfunction

   initial begin
      frame_vec_t  vecs [5];
      logic [12:0] t1347, t2158, t0905;
      int          i0, l0;

      t1347 = {2'd1, 4'd3, 3'd4, 4'd7};
      t2158 = {2'd2, 4'd1, 3'd5, 4'd8};
      t0905 = {2'd0, 4'd9, 3'd0, 4'd5};
      vecs[0] = '{t1347, 1'b0, 59, 1, 1, t1347, 60};
      vecs[1] = '{t1347, 1'b1, 59, 0, 1, t1347, 60};
      vecs[2] = '{t2158, 1'b0, 59, 1, 1, t2158, 60};
      vecs[3] = '{t0905, 1'b0, 58, 0, 1, t2158, 59};
      vecs[4] = '{{2'd2, 4'd5, 3'd3, 4'd0}, 1'b0, 59, 0, 1, t2158, 60};

      rst_n   = 1'b0;
      tick    = 1'b0;
      carrier = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", int'({bus.inc, bus.load, bus.locked}) + time_bus(), 0);
      rst_n = 1'b1;

      tk(1'b1, 20);
      l0 = load_cnt;
      send_marker();
      check("sync_marker_loads", load_cnt - l0, 0);
      check("sync_marker_locked", int'(bus.locked), 0);

      for (int v = 0; v < 5; v++) begin
         i0 = inc_cnt;
         l0 = load_cnt;
         send_secs(vecs[v].f, vecs[v].flip, 1, vecs[v].nsec);
         send_marker();
         check($sformatf("frame%0d_loads", v), load_cnt - l0, vecs[v].exp_loads);
         check($sformatf("frame%0d_incs", v), inc_cnt - i0, vecs[v].exp_incs);
         check($sformatf("frame%0d_locked", v), int'(bus.locked), vecs[v].exp_locked);
         check($sformatf("frame%0d_time", v), time_bus(), int'({vecs[v].exp_time, 7'd0}));
      end

      // Reset at second 30: partial frame discarded, next marker must not load.
      send_secs(t0905, 1'b0, 1, 30);
      tick  = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("midframe_reset_outputs", int'({bus.inc, bus.load, bus.locked}) + time_bus(), 0);
      send_secs(t0905, 1'b0, 31, 59);
      l0 = load_cnt;
      send_marker();
      check("after_reset_marker_loads", load_cnt - l0, 0);
      check("after_reset_marker_locked", int'(bus.locked), 0);

      l0 = load_cnt;
      send_secs(t0905, 1'b0, 1, 59);
      send_marker();
      check("recovered_frame_loads", load_cnt - l0, 1);
      check("recovered_frame_time", time_bus(), int'({t0905, 7'd0}));
      check("recovered_frame_locked", int'(bus.locked), 1);

      // Carrier stays on: lock must survive 139 ticks past the marker edge and drop by 159.
      tick_gap = 2;
      i0       = inc_cnt;
      tk(1'b1, 40);
      check("timeout_not_yet", int'(bus.locked), 1);
      tk(1'b1, 20);
      check("timeout_locked", int'(bus.locked), 0);
      check("timeout_no_inc", inc_cnt - i0, 0);

      tick_gap = 0;
      i0       = inc_cnt;
      tk(1'b0, 1);
      tk(1'b1, 20);
`ifdef MSF_GLITCH_FILTER_EN
      check("glitch_incs", inc_cnt - i0, 0);
`else
      check("glitch_incs", inc_cnt - i0, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
